// File: rtl/seven_seg_digit_driver.sv
// Four-digit seven-segment driver: follows the one-hot ring-counter selector and
// shows frame-consistent shadow data, with blink, leading-zero blanking and selector checking.
module seven_seg_digit_driver #(
  parameter int BLINK_FRAMES   = 250,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1,
  parameter bit LZ_BLANK       = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  selector,
  input  logic [15:0] digits_in,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  blink_mask,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_tick,
  output logic        sel_err
);

  localparam logic [9:0] CNT_MAX = 10'(BLINK_FRAMES - 1);
  localparam logic [3:0] AN_OFF  = {4{AN_ACTIVE_LOW}};
  localparam logic [6:0] SEG_OFF = {7{SEG_ACTIVE_LOW}};

  logic [3:0]  sel_q, sel_prev;
  logic        started;
  logic [15:0] shadow_digits;
  logic [3:0]  shadow_dp, shadow_blink;
  logic [9:0]  blink_cnt;
  logic        blink_phase;

  logic        sel_zero, sel_onehot, sel_illegal, boundary, cnt_wrap;
  logic [15:0] cur_digits;
  logic [3:0]  cur_dp, cur_blink, blank_mask, digit, an_n;
  logic        cur_phase, dp_bit, lz_hide, dp_n;
  logic [6:0]  seg_n;

  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'd0:    decode = 7'b0111111;
      4'd1:    decode = 7'b0000110;
      4'd2:    decode = 7'b1011011;
      4'd3:    decode = 7'b1001111;
      4'd4:    decode = 7'b1100110;
      4'd5:    decode = 7'b1101101;
      4'd6:    decode = 7'b1111101;
      4'd7:    decode = 7'b0000111;
      4'd8:    decode = 7'b1111111;
      4'd9:    decode = 7'b1101111;
      default: decode = 7'b1000000;
    endcase
  endfunction

  // All-zero is only tolerated until the first valid selector after reset.
  assign sel_zero    = (sel_q == 4'b0000);
  assign sel_onehot  = !sel_zero && ((sel_q & (sel_q - 4'd1)) == 4'b0000);
  assign sel_illegal = !sel_onehot && (!sel_zero || started);
  assign boundary    = (sel_q == 4'b0001) && (sel_prev == 4'b1000);
  assign cnt_wrap    = (blink_cnt == CNT_MAX);

  // On the boundary cycle the shadows load at the same edge as the digit-0 output,
  // so that slot uses the incoming values; otherwise the new frame would start torn.
  assign cur_digits = boundary ? digits_in  : shadow_digits;
  assign cur_dp     = boundary ? dp_in      : shadow_dp;
  assign cur_blink  = boundary ? blink_mask : shadow_blink;
  assign cur_phase  = boundary ? (blink_phase ^ cnt_wrap) : blink_phase;

  always_comb begin
    digit  = 4'd0;
    dp_bit = 1'b0;
    case (sel_q)
      4'b0001: begin digit = cur_digits[3:0];   dp_bit = cur_dp[0]; end
      4'b0010: begin digit = cur_digits[7:4];   dp_bit = cur_dp[1]; end
      4'b0100: begin digit = cur_digits[11:8];  dp_bit = cur_dp[2]; end
      4'b1000: begin digit = cur_digits[15:12]; dp_bit = cur_dp[3]; end
      default: begin digit = 4'd0;              dp_bit = 1'b0;      end
    endcase
    lz_hide    = LZ_BLANK && (cur_digits[15:12] == 4'd0);
    blank_mask = (cur_phase ? cur_blink : 4'b0000) | (lz_hide ? 4'b1000 : 4'b0000);
    an_n       = sel_onehot ? (sel_q & ~blank_mask) : 4'b0000;
    seg_n      = sel_onehot ? decode(digit) : 7'b0000000;
    dp_n       = sel_onehot && dp_bit && !(lz_hide && sel_q[3]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q         <= 4'b0000;
      sel_prev      <= 4'b0000;
      started       <= 1'b0;
      shadow_digits <= 16'h0000;
      shadow_dp     <= 4'b0000;
      shadow_blink  <= 4'b0000;
      blink_cnt     <= 10'd0;
      blink_phase   <= 1'b0;
      frame_tick    <= 1'b0;
      sel_err       <= 1'b0;
      an            <= AN_OFF;
      seg           <= SEG_OFF;
      dp            <= SEG_ACTIVE_LOW;
    end else begin
      sel_q      <= selector;
      sel_prev   <= sel_q;
      frame_tick <= boundary;
      if (sel_onehot)  started <= 1'b1;
      if (sel_illegal) sel_err <= 1'b1;
      if (boundary) begin
        shadow_digits <= digits_in;
        shadow_dp     <= dp_in;
        shadow_blink  <= blink_mask;
        if (cnt_wrap) begin
          blink_cnt   <= 10'd0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt   <= blink_cnt + 10'd1;
        end
      end
      an  <= AN_ACTIVE_LOW  ? ~an_n  : an_n;
      seg <= SEG_ACTIVE_LOW ? ~seg_n : seg_n;
      dp  <= SEG_ACTIVE_LOW ? ~dp_n  : dp_n;
    end
  end

endmodule

// File: tb/tb_seven_seg_digit_driver.sv
// Directed bench for seven_seg_digit_driver: scan, frame-consistent loads, blink,
// leading-zero blanking, illegal selector and asynchronous reset.
module tb_seven_seg_digit_driver;

  localparam int BF = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  selector = 4'b0000;
  logic [15:0] digits_in = 16'h0000;
  logic [3:0]  dp_in = 4'b0000;
  logic [3:0]  blink_mask = 4'b0000;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp, frame_tick, sel_err;

  int          tests = 0;
  int          fails = 0;
  logic        ft_mid;
  logic [6:0]  seg_tab [16];

  seven_seg_digit_driver #(
    .BLINK_FRAMES(BF), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1), .LZ_BLANK(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .selector(selector), .digits_in(digits_in), .dp_in(dp_in),
    .blink_mask(blink_mask), .an(an), .seg(seg), .dp(dp), .frame_tick(frame_tick),
    .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  // Drive one selector value for two cycles, starting and ending on a falling edge.
  task automatic slot(input logic [3:0] s);
    selector = s;
    @(negedge clk);
    ft_mid = frame_tick;
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests++; if (an !== 4'b1111) begin fails++; $display("FAIL reset_an: got %b want 1111", an); end
    tests++; if (seg !== 7'b1111111) begin fails++; $display("FAIL reset_seg: got %b want 1111111", seg); end
    tests++; if (dp !== 1'b1) begin fails++; $display("FAIL reset_dp: got %b want 1", dp); end
    tests++; if (frame_tick !== 1'b0) begin fails++; $display("FAIL reset_ft: got %b want 0", frame_tick); end
    tests++; if (sel_err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", sel_err); end
    rst = 1'b0;
    slot(4'b0000);
    tests++; if (sel_err !== 1'b0) begin fails++; $display("FAIL zero_sel_err: got %b want 0", sel_err); end
  endtask

  task automatic test_scan();
    logic [15:0] dig;
    logic [3:0]  s;
    dig = 16'h1234;
    digits_in = dig;
    for (int i = 0; i < 4; i++) begin
      slot(4'b0001 << i);
      tests++; if (frame_tick !== 1'b0 || ft_mid !== 1'b0) begin fails++; $display("FAIL prime_ft slot %0d: got %b/%b want 0/0", i, ft_mid, frame_tick); end
    end
    for (int i = 0; i < 4; i++) begin
      s = 4'b0001 << i;
      slot(s);
      tests++; if (an !== ~s) begin fails++; $display("FAIL scan_an slot %0d: got %b want %b", i, an, ~s); end
      tests++; if (seg !== ~seg_tab[dig[4*i +: 4]]) begin fails++; $display("FAIL scan_seg slot %0d: got %b want %b", i, seg, ~seg_tab[dig[4*i +: 4]]); end
      tests++; if (frame_tick !== (i == 0) || ft_mid !== 1'b0) begin fails++; $display("FAIL scan_ft slot %0d: got %b/%b want 0/%b", i, ft_mid, frame_tick, (i == 0)); end
    end
    slot(4'b0001);
    tests++; if (frame_tick !== 1'b1) begin fails++; $display("FAIL scan_ft_again: got %b want 1", frame_tick); end
    slot(4'b0001);
    tests++; if (frame_tick !== 1'b0 || ft_mid !== 1'b0) begin fails++; $display("FAIL hold_no_retrigger: got %b/%b want 0/0", ft_mid, frame_tick); end
    tests++; if (an !== 4'b1110 || seg !== ~7'b1100110) begin fails++; $display("FAIL hold_display: got %b %b want 1110 %b", an, seg, ~7'b1100110); end
    slot(4'b0010);
    slot(4'b0100);
    slot(4'b1000);
  endtask

  task automatic test_midframe();
    logic [15:0] old_d, new_d;
    logic [3:0]  s;
    old_d = 16'h1234;
    new_d = 16'h5678;
    for (int i = 0; i < 4; i++) begin
      s = 4'b0001 << i;
      if (i == 2) digits_in = new_d;
      slot(s);
      tests++; if (seg !== ~seg_tab[old_d[4*i +: 4]]) begin fails++; $display("FAIL midframe_old slot %0d: got %b want %b", i, seg, ~seg_tab[old_d[4*i +: 4]]); end
    end
    for (int i = 0; i < 4; i++) begin
      s = 4'b0001 << i;
      slot(s);
      tests++; if (seg !== ~seg_tab[new_d[4*i +: 4]] || an !== ~s) begin fails++; $display("FAIL midframe_new slot %0d: got %b %b want %b %b", i, an, seg, ~s, ~seg_tab[new_d[4*i +: 4]]); end
    end
    tests++; if (frame_tick !== 1'b0) begin fails++; $display("FAIL midframe_ft_end: got %b want 0", frame_tick); end
  endtask

  task automatic test_lz();
    digits_in = 16'h0945;
    dp_in = 4'b1000;
    slot(4'b0001);
    tests++; if (seg !== ~seg_tab[5] || frame_tick !== 1'b1) begin fails++; $display("FAIL lz_d0: got %b ft %b want %b ft 1", seg, frame_tick, ~seg_tab[5]); end
    slot(4'b0010);
    slot(4'b0100);
    tests++; if (seg !== ~seg_tab[9] || an !== 4'b1011) begin fails++; $display("FAIL lz_d2: got %b %b want 1011 %b", an, seg, ~seg_tab[9]); end
    slot(4'b1000);
    tests++; if (an !== 4'b1111) begin fails++; $display("FAIL lz_an3: got %b want 1111", an); end
    tests++; if (dp !== 1'b1) begin fails++; $display("FAIL lz_dp3: got %b want 1", dp); end
    digits_in = 16'hA000;
    dp_in = 4'b0000;
    slot(4'b0001);
    tests++; if (seg !== 7'b1000000 || an !== 4'b1110) begin fails++; $display("FAIL dash_d0_zero: got %b %b want 1110 1000000", an, seg); end
    slot(4'b0010);
    slot(4'b0100);
    slot(4'b1000);
    tests++; if (an !== 4'b0111 || seg !== 7'b0111111) begin fails++; $display("FAIL dash_d3: got %b %b want 0111 0111111", an, seg); end
  endtask

  task automatic test_illegal();
    slot(4'b0001);
    slot(4'b0010);
    tests++; if (sel_err !== 1'b0) begin fails++; $display("FAIL err_before: got %b want 0", sel_err); end
    slot(4'b0110);
    tests++; if (an !== 4'b1111) begin fails++; $display("FAIL illegal_an: got %b want 1111", an); end
    tests++; if (sel_err !== 1'b1) begin fails++; $display("FAIL illegal_err: got %b want 1", sel_err); end
    slot(4'b1000);
    tests++; if (an !== 4'b0111 || sel_err !== 1'b1) begin fails++; $display("FAIL resume: got an %b err %b want 0111 1", an, sel_err); end
    slot(4'b0001);
    tests++; if (sel_err !== 1'b1 || frame_tick !== 1'b1) begin fails++; $display("FAIL err_sticky: got err %b ft %b want 1 1", sel_err, frame_tick); end
  endtask

  task automatic test_async_reset();
    #2 rst = 1'b1;
    #1;
    tests++; if (an !== 4'b1111 || seg !== 7'b1111111 || dp !== 1'b1) begin fails++; $display("FAIL async_disp: got %b %b %b want 1111 1111111 1", an, seg, dp); end
    tests++; if (sel_err !== 1'b0 || frame_tick !== 1'b0) begin fails++; $display("FAIL async_flags: got err %b ft %b want 0 0", sel_err, frame_tick); end
    @(negedge clk);
    selector = 4'b0000;
    rst = 1'b0;
    slot(4'b0000);
    tests++; if (sel_err !== 1'b0) begin fails++; $display("FAIL post_reset_err: got %b want 0", sel_err); end
  endtask

  task automatic test_blink();
    int          cnt;
    logic        phase;
    logic [3:0]  s, exp_an;
    cnt = 0;
    phase = 1'b0;
    digits_in = 16'h1234;
    blink_mask = 4'b0011;
    for (int i = 0; i < 4; i++) slot(4'b0001 << i);
    for (int f = 0; f < 8; f++) begin
      if (cnt == BF - 1) begin cnt = 0; phase = ~phase; end
      else cnt++;
      for (int i = 0; i < 4; i++) begin
        s = 4'b0001 << i;
        slot(s);
        exp_an = ~(s & ~(phase ? 4'b0011 : 4'b0000));
        tests++; if (an !== exp_an) begin fails++; $display("FAIL blink_an frame %0d slot %0d: got %b want %b", f, i, an, exp_an); end
      end
    end
  endtask

  initial begin
    seg_tab[0] = 7'b0111111; seg_tab[1] = 7'b0000110; seg_tab[2] = 7'b1011011;
    seg_tab[3] = 7'b1001111; seg_tab[4] = 7'b1100110; seg_tab[5] = 7'b1101101;
    seg_tab[6] = 7'b1111101; seg_tab[7] = 7'b0000111; seg_tab[8] = 7'b1111111;
    seg_tab[9] = 7'b1101111;
    for (int k = 10; k < 16; k++) seg_tab[k] = 7'b1000000;
    test_reset();
    test_scan();
    test_midframe();
    test_lz();
    test_illegal();
    test_async_reset();
    test_blink();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
